// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for the round-robin register-load arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_load_arbiter_pkg;

  // Default geometry: four requesters sharing a 4-bit register
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int PW_DEF    = 2;

  // FSM encoding; LOAD and ACK are single bits so load/busy decode cleanly
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Round-robin winner search: first set req bit after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is pending.
module reg_load_arbiter_rr_pick
  import reg_load_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = PW_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            vld
);

  // Scan ptr+1, ptr+2, ... ptr+NREQ (ptr itself last) and keep the first hit
  always_comb begin
    logic [PW-1:0] w_idx;
    winner = '0;
    vld    = 1'b0;
    w_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = PW'((int'(ptr) + i) % NREQ);
      if (!vld && req[w_idx]) begin
        vld    = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one parallel-load register among NREQ requesters via 4-phase req/ack.
// Latency: req sampled at edge E1 -> register loaded and ack high after E2; ack clears one edge after req low.
// Backpressure: one transaction at a time; other requests wait until the FSM returns to IDLE.
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      a,
  output logic                  load,
  output logic [PW-1:0]         owner,
  output logic                  busy
);

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_a;

  logic [PW-1:0]     w_winner;
  logic              w_vld;
  logic [NREQ-1:0]   w_owner_onehot;

  reg_load_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .vld    (w_vld)
  );

  assign w_owner_onehot = NREQ'(1) << r_owner;

  // Handshake sequencer: arbitrate in IDLE, one LOAD cycle, hold ack until owner releases req
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_owner <= '0;
      r_ack   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_owner <= w_winner;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_ack   <= w_owner_onehot;
          r_ptr   <= r_owner;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          // Only the owner's req matters here; everyone else waits for IDLE
          if (!req[r_owner]) begin
            r_ack   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Shared register: captures the owner's data on the LOAD->ACK edge only
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_a <= '0;
    end else if (r_state == ST_LOAD) begin
      r_a <= data[r_owner*WIDTH +: WIDTH];
    end
  end

  assign load  = (r_state == ST_LOAD);
  assign busy  = (r_state != ST_IDLE);
  assign ack   = r_ack;
  assign a     = r_a;
  assign owner = r_owner;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed self-checking bench for reg_load_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_load_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int PW    = 2;

  logic                  clk = 1'b1;
  logic                  clear = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      a;
  logic                  load;
  logic [PW-1:0]         owner;
  logic                  busy;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;
  int load_base;

  reg_load_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .PW    (PW)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .req   (req),
    .data  (data),
    .ack   (ack),
    .a     (a),
    .load  (load),
    .owner (owner),
    .busy  (busy)
  );

  // Rising edges at 10, 20, 30, ...
  always #5 clk = ~clk;

  // Count load pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (load === 1'b1) load_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (ack === '0 && n < 20) begin
      step();
      n++;
    end
    check("ack_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // ---- 1. Reset ----
    #2 clear = 1'b0;
    #3 clear = 1'b1;
    #1;
    check("rst_a", a, 4'h0);
    check("rst_ack", ack, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 2'd0);
    check("rst_load", load, 1'b0);
    step();
    check("rst_idle_load", load, 1'b0);
    check("rst_load_cnt", load_cnt, 0);

    // ---- 2. Single request ----
    data[0 +: WIDTH] = 4'b0011;
    req = 4'b0001;
    step();
    check("single_load", load, 1'b1);
    check("single_busy", busy, 1'b1);
    check("single_owner", owner, 2'd0);
    check("single_ack_early", ack, 4'h0);
    check("single_a_early", a, 4'h0);
    step();
    check("single_a", a, 4'b0011);
    check("single_ack", ack, 4'b0001);
    check("single_load_off", load, 1'b0);
    req = 4'b0000;
    step();
    check("single_ack_drop", ack, 4'h0);
    check("single_busy_drop", busy, 1'b0);
    check("single_load_cnt", load_cnt, 1);

    // ---- 3. Simultaneous requests (fresh pointer so requester 0 leads) ----
    clear = 1'b0;
    #1 clear = 1'b1;
    data = {4'b0100, 4'b0011, 4'b0010, 4'b0001};
    load_base = load_cnt;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack();
      check("simul_owner", owner, k);
      check("simul_ack", ack, 32'd1 << k);
      check("simul_a", a, k + 1);
      req[k] = 1'b0;
      step();
      check("simul_ack_drop", ack, 4'h0);
    end
    check("simul_load_cnt", load_cnt - load_base, 4);

    // ---- 4. Fairness between requesters 0 and 2 ----
    data = {4'h7, 4'h5, 4'h6, 4'h9};
    req = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      int o;
      o = (t % 2 == 0) ? 0 : 2;
      wait_ack();
      check("fair_owner", owner, o);
      check("fair_a", a, (o == 0) ? 4'h9 : 4'h5);
      req[o] = 1'b0;
      step();
      check("fair_ack_drop", ack, 4'h0);
      if (t == 7) req = 4'b0000;
      else req[o] = 1'b1;
    end
    step();
    check("fair_idle", busy, 1'b0);

    // ---- 5. Reset while requester 1 holds ack ----
    data = {4'h4, 4'h3, 4'h2, 4'h1};
    req = 4'b0010;
    wait_ack();
    check("rstack_pre_ack", ack, 4'b0010);
    check("rstack_pre_a", a, 4'h2);
    clear = 1'b0;
    #1;
    check("rstack_ack", ack, 4'h0);
    check("rstack_a", a, 4'h0);
    check("rstack_busy", busy, 1'b0);
    clear = 1'b1;
    req = 4'b0011;
    step();
    check("rstack_owner", owner, 2'd0);
    check("rstack_load", load, 1'b1);
    step();
    check("rstack_ack0", ack, 4'b0001);
    check("rstack_a0", a, 4'h1);
    req = 4'b0000;
    step();
    check("rstack_release", ack, 4'h0);

    // ---- 6. Early drop during LOAD ----
    data[3*WIDTH +: WIDTH] = 4'b1010;
    req = 4'b1000;
    step();
    check("early_load", load, 1'b1);
    check("early_owner", owner, 2'd3);
    load_base = load_cnt;
    req = 4'b0000;
    step();
    check("early_a", a, 4'b1010);
    check("early_ack", ack, 4'b1000);
    step();
    check("early_ack_pulse", ack, 4'h0);
    check("early_busy", busy, 1'b0);
    step();
    step();
    check("early_no_reload", load_cnt - load_base, 1);
    check("early_a_hold", a, 4'b1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
Name: reg_load_arbiter

Overview:
Round-robin arbiter that shares one parallel-load register among NREQ requesters. It uses a 4-phase req/ack handshake. It sequences exactly one load per granted transaction and drives the register's load strobe and data. The register is held internally, so the block's output is the shared register value. It sits between several producer blocks and any consumer of the shared register.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, register/data width in bits
PW, 2, pointer/owner index width; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge active
clear  input  1  asynchronous reset, active-low
req  input  NREQ  request lines, one per requester; bit k = requester k
data  input  NREQ*WIDTH  flattened load data; requester k uses bits [k*WIDTH +: WIDTH]
ack  output  NREQ  acknowledge, one-hot or zero
a  output  WIDTH  shared register contents
load  output  1  load strobe to register, high for exactly one cycle per grant
owner  output  PW  index of current/last granted requester
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (clear low, asynchronous, overrides everything):
  - state=IDLE, a=0, ack=0, load=0, busy=0, owner=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts the transaction; ack falls immediately.
- FSM states: IDLE, LOAD, ACK.
- IDLE:
  - If req != 0 at a rising edge, pick the winner: the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - owner <= winner; state <= LOAD.
  - If req == 0, stay in IDLE.
- LOAD (exactly one cycle):
  - load=1 (decoded from state).
  - At the next edge: a <= data slice of owner; ack[owner] <= 1; ptr <= owner; state <= ACK.
  - Data is sampled at this edge only. A requester must hold data stable from raising req until it sees ack.
- ACK:
  - ack[owner] is held high.
  - On the first edge that samples req[owner]==0: ack <= 0, state <= IDLE.
  - Other requests are ignored in this state.
- Latency:
  - Request sampled at edge E1 → a updated and ack high after E2.
  - Requester drops req; ack clears one edge after req low is sampled.
  - Minimum 3 cycles per transaction; next arbitration is no earlier than the edge after returning to IDLE.
- Simultaneous requests: resolved strictly round-robin. A continuously requesting set is served in rotating order with no starvation.
- Protocol violation (req[owner] drops during LOAD): the load still completes and ack[owner] pulses for one cycle, since ACK sees req low at its first edge. Then IDLE.
- Register holds its value at all times except the LOAD→ACK edge and reset. No width extension or truncation: the data slice width equals WIDTH.
- All outputs are registered except load and busy, which are decoded from the state register (glitch-free, one-hot state encoding permitted).

Decomposition:
- Shared header/package holds:
  - state encoding constants: IDLE=2'b00, LOAD=2'b01, ACK=2'b10;
  - default WIDTH and NREQ.
- One natural sub-module, rr_pick:
  - purely combinational;
  - inputs req and ptr; outputs winner index and a valid flag.
  - Verified standalone.
- The register is plain behavioural code inside reg_load_arbiter, with async clear and synchronous load.

Test Plan:
1. Reset: clear low at t=2, high at t=5, while req=0000 → a=0000, ack=0000, busy=0, owner=0; no load pulse.
2. Single request: req=0001 with data0=0011 → load high for one cycle; a=0011 and ack=0001 after the 2nd edge; requester drops req → ack=0000 one edge later; busy falls.
3. Simultaneous requests: req=1111 with data0..3=0001/0010/0011/0100; each requester drops req on ack and stays low → grant order 0,1,2,3; a sequence 0001,0010,0011,0100; exactly 4 load pulses.
4. Fairness: requesters 0 and 2 re-raise req one cycle after each ack drop, for 8 transactions → owner alternates 0,2,0,2,...; requester 0 never wins twice in a row.
5. Reset mid-ACK: clear pulsed low for 1 ns while ack=0010 → ack=0000 and a=0000 immediately, state IDLE; with req=0011 afterwards, requester 0 wins first.
6. Early drop: requester 3 raises req with data3=1010, then drops req during LOAD → a=1010, ack=1000 for exactly one cycle, then IDLE; no further load.
